// File: rtl/wb_coproc_seq.sv
// Wishbone-classic master that sequences operand writes and the result read of the
// shift/logic coprocessor for a single valid/ready command client, caching last operands.
module wb_coproc_seq #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned OPW = 3;
  localparam int unsigned CW  = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR_A = 3'd1;
  localparam logic [2:0] S_WR_B = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  localparam logic [AW-1:0] ADR_A   = 5'h00;
  localparam logic [AW-1:0] ADR_B   = 5'h04;
  localparam logic [AW-1:0] ADR_RES = 5'h08;

  logic [2:0]     state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [DW-1:0]  a_q, a_d, b_q, b_d;
  logic [DW-1:0]  last_a_q, last_a_d, last_b_q, last_b_d;
  logic           a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           cmd_ready_d, rsp_valid_d, rsp_err_d;
  logic [DW-1:0]  rsp_data_d;
  logic           cyc_d, stb_d, we_d;
  logic [AW-1:0]  adr_d;
  logic [DW-1:0]  dat_d;

  logic           cmd_illegal, cmd_a_hit, cmd_b_hit, q_b_hit, tmo_hit;
  logic [CW:0]    cnt_inc;
  logic [AW-1:0]  rd_adr_cmd, rd_adr_q;

  assign cmd_illegal = cmd_op[2] & cmd_op[1];
  assign cmd_a_hit   = a_vld_q && (last_a_q == cmd_a);
  assign cmd_b_hit   = b_vld_q && (last_b_q == cmd_b);
  assign q_b_hit     = b_vld_q && (last_b_q == b_q);
  assign cnt_inc     = {1'b0, cnt_q} + (CW+1)'(1);
  assign tmo_hit     = (cnt_inc == (CW+1)'(TIMEOUT));
  assign rd_adr_cmd  = ADR_RES + {cmd_op, 2'b00};
  assign rd_adr_q    = ADR_RES + {op_q, 2'b00};

  // Next-state and next-output logic; every register has its next value computed here.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    last_a_d    = last_a_q;
    last_b_d    = last_b_q;
    a_vld_d     = a_vld_q;
    b_vld_d     = b_vld_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    cyc_d       = wb_cyc_o;
    stb_d       = wb_stb_o;
    we_d        = wb_we_o;
    adr_d       = wb_adr_o;
    dat_d       = wb_dat_o;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d        = cmd_op;
          a_d         = cmd_a;
          b_d         = cmd_b;
          cmd_ready_d = 1'b0;
          if (cmd_illegal) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            cnt_d = '0;
            cyc_d = 1'b1;
            stb_d = 1'b1;
            if (!cmd_a_hit) begin
              state_d = S_WR_A;
              we_d    = 1'b1;
              adr_d   = ADR_A;
              dat_d   = cmd_a;
            end else if (!cmd_b_hit) begin
              state_d = S_WR_B;
              we_d    = 1'b1;
              adr_d   = ADR_B;
              dat_d   = cmd_b;
            end else begin
              state_d = S_RD;
              we_d    = 1'b0;
              adr_d   = rd_adr_cmd;
              dat_d   = '0;
            end
          end
        end
      end

      S_WR_A, S_WR_B, S_RD: begin
        if (wb_ack_i) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          if (state_q == S_WR_A) begin
            last_a_d = a_q;
            a_vld_d  = 1'b1;
            state_d  = S_GAP;
          end else if (state_q == S_WR_B) begin
            last_b_d = b_q;
            b_vld_d  = 1'b1;
            state_d  = S_GAP;
          end else begin
            rsp_data_d  = wb_dat_i;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end
        end else if (tmo_hit) begin
          // Slave is unresponsive: its operand registers can no longer be trusted.
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          a_vld_d     = 1'b0;
          b_vld_d     = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end

      // After WR_B the B cache always hits, so one check covers both predecessors.
      S_GAP: begin
        cnt_d = '0;
        cyc_d = 1'b1;
        stb_d = 1'b1;
        if (!q_b_hit) begin
          state_d = S_WR_B;
          we_d    = 1'b1;
          adr_d   = ADR_B;
          dat_d   = b_q;
        end else begin
          state_d = S_RD;
          we_d    = 1'b0;
          adr_d   = rd_adr_q;
          dat_d   = '0;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      last_a_q  <= '0;
      last_b_q  <= '0;
      a_vld_q   <= 1'b0;
      b_vld_q   <= 1'b0;
      cnt_q     <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      last_a_q  <= last_a_d;
      last_b_q  <= last_b_d;
      a_vld_q   <= a_vld_d;
      b_vld_q   <= b_vld_d;
      cnt_q     <= cnt_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      wb_cyc_o  <= cyc_d;
      wb_stb_o  <= stb_d;
      wb_we_o   <= we_d;
      wb_adr_o  <= adr_d;
      wb_dat_o  <= dat_d;
    end
  end

endmodule

// File: tb/tb_wb_coproc_seq.sv
// Directed bench for wb_coproc_seq: a coprocessor slave model with registered ack,
// and scoreboards of expected bus transfers and responses.
module tb_wb_coproc_seq;

  typedef struct packed {
    logic        we;
    logic [4:0]  adr;
    logic [31:0] dat;
  } bus_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [4:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  logic        slave_en = 1'b1;
  logic [31:0] reg_a, reg_b;

  bus_t exp_bus[$];
  rsp_t exp_rsp[$];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int last_stb_cycles;
  bit last_saw_cyc;

  always #5 clk = ~clk;

  wb_coproc_seq #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  function automatic logic [31:0] coproc(input logic [4:0] adr, input logic [31:0] a,
                                         input logic [31:0] b);
    case (adr)
      5'h08:   coproc = a << b[4:0];
      5'h0C:   coproc = a >> b[4:0];
      5'h10:   coproc = 32'($signed(a) >>> b[4:0]);
      5'h14:   coproc = a & b;
      5'h18:   coproc = a | b;
      5'h1C:   coproc = a ^ b;
      default: coproc = 32'hDEAD_BEEF;
    endcase
  endfunction

  // Coprocessor slave: registered ack one cycle after strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_i <= 1'b0;
      wb_dat_i <= '0;
      reg_a    <= '0;
      reg_b    <= '0;
    end else begin
      wb_ack_i <= slave_en & wb_cyc_o & wb_stb_o & ~wb_ack_i;
      if (slave_en && wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_we_o)
        wb_dat_i <= coproc(wb_adr_o, reg_a, reg_b);
      if (wb_cyc_o && wb_stb_o && wb_ack_i && wb_we_o) begin
        if (wb_adr_o == 5'h00) reg_a <= wb_dat_o;
        if (wb_adr_o == 5'h04) reg_b <= wb_dat_o;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_bus(input logic we, input logic [4:0] adr, input logic [31:0] dat);
    bus_t e;
    e.we = we; e.adr = adr; e.dat = dat;
    exp_bus.push_back(e);
  endtask

  task automatic push_rsp(input logic [31:0] data, input logic err);
    rsp_t r;
    r.data = data; r.err = err;
    exp_rsp.push_back(r);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"},  rsp_data,       32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    chk({tag, "_cyc"},       32'(wb_cyc_o),  32'd0);
    chk({tag, "_stb"},       32'(wb_stb_o),  32'd0);
    chk({tag, "_we"},        32'(wb_we_o),   32'd0);
    chk({tag, "_adr"},       32'(wb_adr_o),  32'd0);
    chk({tag, "_dat"},       wb_dat_o,       32'd0);
  endtask

  // Issue one command, check bus transfers, gaps, latency and response, then complete handshake.
  task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input int hold);
    int   lat = 0;
    bit   seen = 0;
    bit   after_ack = 0;
    int   gap = 0;
    bit   saw_cyc = 0;
    int   stb_cycles = 0;
    bus_t e;
    rsp_t r;
    @(negedge clk);
    chk("cmd_ready_pre", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int n = 1; n <= 200 && !seen; n++) begin
      @(negedge clk);
      if (wb_cyc_o) saw_cyc = 1;
      if (wb_stb_o) begin
        stb_cycles++;
        if (after_ack) begin
          chk("gap_len", 32'(gap), 32'd1);
          after_ack = 0;
        end
        if (wb_ack_i) begin
          chk("bus_expected", 32'(exp_bus.size() != 0), 32'd1);
          if (exp_bus.size() != 0) begin
            e = exp_bus.pop_front();
            chk("bus_we",  32'(wb_we_o),  32'(e.we));
            chk("bus_adr", 32'(wb_adr_o), 32'(e.adr));
            chk("bus_dat", wb_dat_o,      e.dat);
          end
          after_ack = 1;
          gap = 0;
        end
      end else if (after_ack) begin
        gap++;
      end
      if (rsp_valid) begin
        seen = 1;
        lat = n;
      end
    end
    chk("rsp_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    r = exp_rsp.pop_front();
    chk("rsp_data", rsp_data, r.data);
    chk("rsp_err", 32'(rsp_err), 32'(r.err));
    chk("bus_q_empty", 32'(exp_bus.size()), 32'd0);
    last_stb_cycles = stb_cycles;
    last_saw_cyc = saw_cyc;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", rsp_data, r.data);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // SLL, no cache hit.
    push_bus(1'b1, 5'h00, 32'h1); push_bus(1'b1, 5'h04, 32'h4); push_bus(1'b0, 5'h08, 32'h0);
    push_rsp(32'h10, 1'b0);
    run_cmd(3'd0, 32'h1, 32'h4, 9, 0);

    // XOR, both operands cached.
    push_bus(1'b0, 5'h1C, 32'h0);
    push_rsp(32'h5, 1'b0);
    run_cmd(3'd5, 32'h1, 32'h4, 3, 0);

    // OR with new A only.
    push_bus(1'b1, 5'h00, 32'h8000_0000); push_bus(1'b0, 5'h18, 32'h0);
    push_rsp(32'h8000_0004, 1'b0);
    run_cmd(3'd4, 32'h8000_0000, 32'h4, 6, 0);

    // SRA with A cached, new B.
    push_bus(1'b1, 5'h04, 32'h1F); push_bus(1'b0, 5'h10, 32'h0);
    push_rsp(32'hFFFF_FFFF, 1'b0);
    run_cmd(3'd2, 32'h8000_0000, 32'h1F, 6, 0);

    // Illegal op: no bus cycle, cache untouched.
    push_rsp(32'h0, 1'b1);
    run_cmd(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0);
    chk("illegal_no_cyc", 32'(last_saw_cyc), 32'd0);
    push_bus(1'b0, 5'h18, 32'h0);
    push_rsp(32'h8000_001F, 1'b0);
    run_cmd(3'd4, 32'h8000_0000, 32'h1F, 3, 0);

    // Timeout during the read phase.
    slave_en = 1'b0;
    push_rsp(32'h0, 1'b1);
    run_cmd(3'd5, 32'h8000_0000, 32'h1F, 16, 0);
    chk("timeout_stb_cycles", 32'(last_stb_cycles), 32'd15);
    chk("timeout_cyc_low", 32'(wb_cyc_o), 32'd0);
    slave_en = 1'b1;
    push_bus(1'b1, 5'h00, 32'h8000_0000); push_bus(1'b1, 5'h04, 32'h1F);
    push_bus(1'b0, 5'h1C, 32'h0);
    push_rsp(32'h8000_001F, 1'b0);
    run_cmd(3'd5, 32'h8000_0000, 32'h1F, 9, 0);

    // Response back-pressure.
    rsp_ready = 1'b0;
    push_bus(1'b1, 5'h00, 32'h3); push_bus(1'b1, 5'h04, 32'h2); push_bus(1'b0, 5'h08, 32'h0);
    push_rsp(32'hC, 1'b0);
    run_cmd(3'd0, 32'h3, 32'h2, 9, 5);

    // Reset during WR_B (A=3 cached, B misses).
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 32'h3; cmd_b = 32'h1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_stb_high", 32'(wb_stb_o), 32'd1);
    chk("mid_adr_b", 32'(wb_adr_o), 32'h04);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk) rst_n = 1'b1;
    push_bus(1'b1, 5'h00, 32'h3); push_bus(1'b1, 5'h04, 32'h1); push_bus(1'b0, 5'h0C, 32'h0);
    push_rsp(32'h1, 1'b0);
    run_cmd(3'd1, 32'h3, 32'h1, 9, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
